// File: rtl/dmem_ctrl_pkg.sv
// Shared types and lane helpers for the doubleword data-memory controller.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4
    } state_e;

    // Pull the addressed lane out of a doubleword and widen it to 64 bits.
    function automatic logic [63:0] lane_extract(input logic [63:0] data,
                                                 input logic [2:0]  off,
                                                 input size_e       size,
                                                 input logic        is_unsigned);
        logic [63:0] sh;
        sh = data >> {off, 3'b000};
        case (size)
            SZ_B:    return is_unsigned ? {56'd0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
            SZ_H:    return is_unsigned ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            SZ_W:    return is_unsigned ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: return data;
        endcase
    endfunction

    // Replace the addressed lane of old_data with the low bytes of new_data.
    function automatic logic [63:0] lane_merge(input logic [63:0] old_data,
                                               input logic [63:0] new_data,
                                               input logic [2:0]  off,
                                               input size_e       size);
        logic [63:0] mask;
        case (size)
            SZ_B:    mask = 64'h0000_0000_0000_00FF;
            SZ_H:    mask = 64'h0000_0000_0000_FFFF;
            SZ_W:    mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return (old_data & ~(mask << {off, 3'b000})) |
               ((new_data & mask) << {off, 3'b000});
    endfunction

endpackage

// File: rtl/dmem_ctrl_rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer holds the last granted port.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    logic ptr;

    // Contention goes to the port not granted last; a lone requester always wins.
    always_comb begin
        gnt_idx = (req == 2'b11) ? ~ptr : req[1];
        gnt     = 2'b00;
        if (req != 2'b00) begin
            gnt = gnt_idx ? 2'b10 : 2'b01;
        end
    end

    // Pointer starts at 1 so port 0 wins the first contended grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b1;
        end else if (advance) begin
            ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: two-port arbitration, RV64I load extension and
// read-modify-write for sub-doubleword stores on a doubleword-only memory.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int DEPTH = 2048
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [1:0]      req_we,
    input  logic [1:0][1:0] req_size,
    input  logic [1:0]      req_unsigned,
    input  logic [1:0][63:0] req_addr,
    input  logic [1:0][63:0] req_wdata,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [63:0]     rsp_rdata,
    output logic            rsp_err,
    output logic [63:0]     mem_addr,
    output logic [63:0]     mem_wr_data,
    output logic            mem_wr_en,
    input  logic [63:0]     mem_rd_data
);

    state_e      state;
    logic [1:0]  gnt;
    logic        gnt_idx;
    logic        hs;
    logic        owner_q;
    logic [1:0]  owner_oh;
    logic [2:0]  off_q;
    size_e       size_q;
    logic        uns_q;
    logic [63:0] wdata_q;
    size_e       sel_size;
    logic [63:0] sel_addr;
    logic [64:0] end_addr;
    logic        misalign;
    logic        oor;
    logic        sel_err;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (hs),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = (state == IDLE) ? gnt : 2'b00;
    assign hs        = |req_ready;
    assign owner_oh  = owner_q ? 2'b10 : 2'b01;

    // Classify the granted request; the end address is 65 bits so it cannot wrap.
    always_comb begin
        sel_size = size_e'(req_size[gnt_idx]);
        sel_addr = req_addr[gnt_idx];
        case (sel_size)
            SZ_B:    misalign = 1'b0;
            SZ_H:    misalign = sel_addr[0];
            SZ_W:    misalign = |sel_addr[1:0];
            default: misalign = |sel_addr[2:0];
        endcase
        end_addr = {1'b0, sel_addr} + (65'd1 << sel_size);
        oor      = end_addr > 65'(DEPTH);
        sel_err  = misalign | oor;
    end

    // Latch the request fields the later states need; pure data, no reset.
    always_ff @(posedge clk) begin
        if (hs) begin
            off_q   <= sel_addr[2:0];
            size_q  <= sel_size;
            uns_q   <= req_unsigned[gnt_idx];
            wdata_q <= req_wdata[gnt_idx];
        end
    end

    // Transaction FSM; every memory-side and response output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner_q     <= 1'b0;
            rsp_valid   <= 2'b00;
            rsp_rdata   <= 64'd0;
            rsp_err     <= 1'b0;
            mem_addr    <= 64'd0;
            mem_wr_data <= 64'd0;
            mem_wr_en   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        owner_q <= gnt_idx;
                        if (sel_err) begin
                            rsp_valid <= gnt;
                            rsp_rdata <= 64'd0;
                            rsp_err   <= 1'b1;
                            state     <= RESP;
                        end else begin
                            mem_addr <= {sel_addr[63:3], 3'b000};
                            if (!req_we[gnt_idx]) begin
                                state <= LOAD;
                            end else if (sel_size == SZ_D) begin
                                mem_wr_data <= req_wdata[gnt_idx];
                                mem_wr_en   <= 1'b1;
                                state       <= WR;
                            end else begin
                                state <= RMW_RD;
                            end
                        end
                    end
                end
                LOAD: begin
                    rsp_rdata <= lane_extract(mem_rd_data, off_q, size_q, uns_q);
                    rsp_err   <= 1'b0;
                    rsp_valid <= owner_oh;
                    mem_addr  <= 64'd0;
                    state     <= RESP;
                end
                RMW_RD: begin
                    // Merge straight into the write register so WR only strobes.
                    mem_wr_data <= lane_merge(mem_rd_data, wdata_q, off_q, size_q);
                    mem_wr_en   <= 1'b1;
                    state       <= WR;
                end
                WR: begin
                    mem_wr_en   <= 1'b0;
                    mem_wr_data <= 64'd0;
                    mem_addr    <= 64'd0;
                    rsp_rdata   <= 64'd0;
                    rsp_err     <= 1'b0;
                    rsp_valid   <= owner_oh;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner_q]) begin
                        rsp_valid <= 2'b00;
                        rsp_rdata <= 64'd0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl with a behavioural doubleword memory and a
// byte-level reference model feeding a response scoreboard.
module tb_dmem_ctrl;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [1:0]       req_we = 2'b00;
    logic [1:0][1:0]  req_size = '0;
    logic [1:0]       req_unsigned = 2'b00;
    logic [1:0][63:0] req_addr = '0;
    logic [1:0][63:0] req_wdata = '0;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready = 2'b11;
    logic [63:0]      rsp_rdata;
    logic             rsp_err;
    logic [63:0]      mem_addr;
    logic [63:0]      mem_wr_data;
    logic             mem_wr_en;
    logic [63:0]      mem_rd_data;

    logic [63:0] mem [0:255] = '{default: 64'd0};
    logic [7:0]  ref_bytes [0:2047] = '{default: 8'h00};
    int          cyc = 0;
    int          wr_count = 0;
    logic [63:0] last_wr_addr = 64'd0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int          port;
        logic [63:0] rdata;
        logic        err;
        int          n;
        int          lat;
        int          wr_delta;
    } exp_t;
    exp_t sb[$];

    dmem_ctrl #(.DEPTH(2048)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_en    (mem_wr_en),
        .mem_rd_data  (mem_rd_data)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory: combinational read, write on the clock edge.
    assign mem_rd_data = mem[mem_addr[10:3]];
    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr[10:3]] <= mem_wr_data;
            wr_count            <= wr_count + 1;
            last_wr_addr        <= mem_addr;
        end
    end

    // Reference load built byte by byte from the little-endian byte image.
    function automatic logic [63:0] model_load(input logic [63:0] a, input logic [1:0] sz,
                                               input logic uns);
        logic [63:0] v;
        int nb;
        v  = 64'd0;
        nb = 1 << int'(sz);
        for (int i = 0; i < nb; i++) v[i*8 +: 8] = ref_bytes[int'(a[10:0]) + i];
        if (!uns && nb < 8 && v[nb*8-1]) begin
            for (int i = nb; i < 8; i++) v[i*8 +: 8] = 8'hFF;
        end
        return v;
    endfunction

    function automatic logic model_err(input logic [63:0] a, input logic [1:0] sz);
        int nb;
        nb = 1 << int'(sz);
        return ((int'(a[2:0]) % nb) != 0) || (a > 64'd2048) || (longint'(a) + nb > 2048);
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One complete transaction on port p with scoreboard-based response checks.
    task automatic do_req(input int p, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wd, input string name);
        exp_t e;
        logic ok;
        int   w0;
        @(negedge clk);
        req_valid[p] = 1'b1;
        req_we[p] = we;
        req_size[p] = sz;
        req_unsigned[p] = uns;
        req_addr[p] = addr;
        req_wdata[p] = wd;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (req_ready[p]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s grant: req_ready=%b required port %0d", name, req_ready, p);
            req_valid[p] = 1'b0;
            return;
        end
        w0 = wr_count;
        e.port = p;
        e.n    = cyc;
        e.err  = model_err(addr, sz);
        e.lat  = e.err ? 1 : ((!we || sz == 2'd3) ? 2 : 3);
        e.wr_delta = (we && !e.err) ? 1 : 0;
        e.rdata = (we || e.err) ? 64'd0 : model_load(addr, sz, uns);
        if (we && !e.err) begin
            for (int i = 0; i < (1 << int'(sz)); i++) ref_bytes[int'(addr[10:0]) + i] = wd[i*8 +: 8];
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        e = sb.pop_front();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s rsp timeout: rsp_valid=%b required port %0d", name, rsp_valid, e.port);
            return;
        end
        checks++;
        if (rsp_valid !== (e.port == 1 ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL %s rsp_valid: got %b required port %0d", name, rsp_valid, e.port);
        end
        checks++;
        if (rsp_rdata !== e.rdata) begin
            errors++;
            $display("FAIL %s rdata: got %h required %h", name, rsp_rdata, e.rdata);
        end
        checks++;
        if (rsp_err !== e.err) begin
            errors++;
            $display("FAIL %s err: got %b required %b", name, rsp_err, e.err);
        end
        checks++;
        if (cyc - e.n !== e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", name, cyc - e.n, e.lat);
        end
        checks++;
        if (wr_count - w0 !== e.wr_delta) begin
            errors++;
            $display("FAIL %s write count: got %0d required %0d", name, wr_count - w0, e.wr_delta);
        end
        checks++;
        if (mem_addr !== 64'd0 || mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL %s resp mem side: mem_addr=%h wr_en=%b required 0", name, mem_addr, mem_wr_en);
        end
        if (e.wr_delta == 1) begin
            checks++;
            if (last_wr_addr !== {addr[63:3], 3'b000}) begin
                errors++;
                $display("FAIL %s write addr: got %h required %h", name, last_wr_addr,
                         {addr[63:3], 3'b000});
            end
        end
    endtask

    task automatic test_reset();
        pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset ctrl: req_ready=%b rsp_valid=%b rsp_err=%b required 0",
                     req_ready, rsp_valid, rsp_err);
        end
        checks++;
        if (rsp_rdata !== 64'd0 || mem_addr !== 64'd0) begin
            errors++;
            $display("FAIL reset data: rsp_rdata=%h mem_addr=%h required 0", rsp_rdata, mem_addr);
        end
        checks++;
        if (mem_wr_data !== 64'd0 || mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset write: mem_wr_data=%h mem_wr_en=%b required 0", mem_wr_data, mem_wr_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_load_d();
        do_req(0, 1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, "sd_0x10");
        do_req(0, 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, "ld_0x10");
    endtask

    task automatic test_subword_store();
        do_req(0, 1'b1, 2'd0, 1'b0, 64'h13, 64'h00000000000000AB, "sb_0x13");
        do_req(0, 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, "ld_after_sb");
        checks++;
        if (mem[2] !== 64'h11223344AB667788) begin
            errors++;
            $display("FAIL sb memory image: got %h required %h", mem[2], 64'h11223344AB667788);
        end
    endtask

    task automatic test_extension();
        do_req(0, 1'b0, 2'd0, 1'b0, 64'h13, 64'd0, "lb_0x13");
        do_req(0, 1'b0, 2'd0, 1'b1, 64'h13, 64'd0, "lbu_0x13");
        do_req(0, 1'b0, 2'd2, 1'b0, 64'h10, 64'd0, "lw_0x10");
        do_req(0, 1'b0, 2'd1, 1'b1, 64'h16, 64'd0, "lhu_0x16");
        do_req(1, 1'b0, 2'd1, 1'b0, 64'h14, 64'd0, "lh_port1_0x14");
    endtask

    task automatic test_errors();
        do_req(0, 1'b1, 2'd2, 1'b0, 64'h12, 64'hDEADBEEFDEADBEEF, "sw_misaligned");
        do_req(0, 1'b0, 2'd3, 1'b0, 64'h7FC, 64'd0, "ld_out_of_range");
        do_req(1, 1'b0, 2'd3, 1'b0, 64'h7F8, 64'd0, "ld_last_dword");
        checks++;
        if (mem[2] !== 64'h11223344AB667788) begin
            errors++;
            $display("FAIL error memory image: got %h required %h", mem[2], 64'h11223344AB667788);
        end
    endtask

    task automatic test_arbitration();
        int          grants[$];
        int          n_rsp;
        int          bp_left;
        logic        seen;
        logic        drop;
        logic [63:0] held_data;
        logic [1:0]  held_vld;
        exp_t        e;
        int          p;
        pulse_reset();
        @(negedge clk);
        req_we = 2'b00;
        req_size[0] = 2'd3; req_unsigned[0] = 1'b0; req_addr[0] = 64'h10;
        req_size[1] = 2'd1; req_unsigned[1] = 1'b0; req_addr[1] = 64'h16;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        n_rsp = 0; bp_left = 3; seen = 1'b0; drop = 1'b0;
        held_data = 64'd0; held_vld = 2'b00;
        for (int c = 0; c < 100 && n_rsp < 4; c++) begin
            #1;
            if (drop) req_valid = 2'b00;
            if (req_ready != 2'b00) begin
                p = req_ready[1] ? 1 : 0;
                grants.push_back(p);
                e.port = p; e.n = cyc; e.err = 1'b0; e.lat = 2; e.wr_delta = 0;
                e.rdata = model_load(req_addr[p], req_size[p], req_unsigned[p]);
                sb.push_back(e);
                if (grants.size() == 4) drop = 1'b1;
            end
            if (rsp_valid != 2'b00) begin
                checks++;
                if (req_ready !== 2'b00) begin
                    errors++;
                    $display("FAIL arb req_ready during resp: got %b required 00", req_ready);
                end
                if (!seen) begin
                    seen = 1'b1;
                    e = sb.pop_front();
                    held_data = rsp_rdata;
                    held_vld  = rsp_valid;
                    checks++;
                    if (rsp_valid !== (e.port == 1 ? 2'b10 : 2'b01) || rsp_rdata !== e.rdata) begin
                        errors++;
                        $display("FAIL arb rsp: valid=%b rdata=%h required port %0d rdata %h",
                                 rsp_valid, rsp_rdata, e.port, e.rdata);
                    end
                    checks++;
                    if (cyc - e.n !== e.lat) begin
                        errors++;
                        $display("FAIL arb latency: got %0d required %0d", cyc - e.n, e.lat);
                    end
                end else begin
                    checks++;
                    if (rsp_valid !== held_vld || rsp_rdata !== held_data) begin
                        errors++;
                        $display("FAIL arb hold: valid=%b rdata=%h required %b %h",
                                 rsp_valid, rsp_rdata, held_vld, held_data);
                    end
                end
                if (bp_left > 0) begin
                    bp_left--;
                    rsp_ready = 2'b00;
                end else begin
                    rsp_ready = 2'b11;
                    seen = 1'b0;
                    n_rsp++;
                end
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        checks++;
        if (n_rsp != 4) begin
            errors++;
            $display("FAIL arb completion: got %0d responses required 4", n_rsp);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= grants.size() || grants[i] != (i % 2)) begin
                errors++;
                $display("FAIL arb grant %0d: got %0d required %0d", i,
                         (i < grants.size()) ? grants[i] : -1, i % 2);
            end
        end
        sb.delete();
    endtask

    task automatic test_reset_rmw();
        int   w0;
        logic ok;
        do_req(0, 1'b1, 2'd3, 1'b0, 64'h18, 64'hCAFEF00D12345678, "sd_0x18");
        w0 = wr_count;
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = 2'd1; req_unsigned[0] = 1'b0;
        req_addr[0] = 64'h18; req_wdata[0] = 64'h000000000000BEEF;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (req_ready[0]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rmw grant: req_ready=%b required 01", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_addr !== 64'h18 || mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL rmw read phase: mem_addr=%h wr_en=%b required 18 0", mem_addr, mem_wr_en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 2'b00 || mem_addr !== 64'd0 || mem_wr_en !== 1'b0 ||
            mem_wr_data !== 64'd0 || rsp_rdata !== 64'd0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL rmw reset outputs: rsp_valid=%b mem_addr=%h wr_en=%b wr_data=%h rdata=%h required 0",
                     rsp_valid, mem_addr, mem_wr_en, mem_wr_data, rsp_rdata);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wr_count !== w0) begin
            errors++;
            $display("FAIL rmw reset write: got %0d writes required 0", wr_count - w0);
        end
        rst_n = 1'b1;
        do_req(0, 1'b0, 2'd3, 1'b0, 64'h18, 64'd0, "ld_after_reset");
    endtask

    initial begin
        test_reset();
        test_store_load_d();
        test_subword_store();
        test_extension();
        test_errors();
        test_arbitration();
        test_reset_rmw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
